// File: rtl/step_seq_pkg.sv
// Shared constants, FSM state type and tempo helper for the step sequencer.
package step_seq_pkg;

  localparam int CLK_HZ         = 50_000_000;
  localparam int STEPS_PER_BEAT = 4;
  localparam int NUM_STEPS      = 16;
  localparam int PULSE_W        = 4;
  localparam int BPM_MIN        = 40;
  localparam int BPM_MAX        = 240;
  localparam int PERIOD_W       = 32;
  localparam int STEP_IDX_W     = $clog2(NUM_STEPS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RUN
  } step_state_e;

  // Clamp a requested tempo into [lo, hi]; keeps the divisor away from zero.
  function automatic logic [7:0] clamp_bpm(input logic [7:0] bpm, input int lo, input int hi);
    if (int'(bpm) < lo)      clamp_bpm = 8'(lo);
    else if (int'(bpm) > hi) clamp_bpm = 8'(hi);
    else                     clamp_bpm = bpm;
  endfunction

endpackage

// File: rtl/step_period_div.sv
// Restoring divider, one quotient bit per cycle. The first quotient bit is
// resolved on the Start edge, so Done pulses 32 cycles after Start is sampled
// (33 cycles counting the Start cycle itself).
module step_period_div
  import step_seq_pkg::*;
#(
  parameter int NUM_W = PERIOD_W,
  parameter int DEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CNT_W = $clog2(NUM_W);

  logic [DEN_W-1:0] rem;
  logic [DEN_W-1:0] den;
  logic [NUM_W-1:0] quo;     // remaining numerator bits shift out, quotient bits shift in
  logic [CNT_W-1:0] cnt;
  logic [DEN_W:0]   ld_step; // {quotient bit, new remainder}
  logic [DEN_W:0]   it_step;

  // One restoring step: bring in the next numerator bit, subtract if it fits.
  function automatic logic [DEN_W:0] div_bit(input logic [DEN_W-1:0] r, input logic b,
                                             input logic [DEN_W-1:0] d);
    logic [DEN_W:0] trial;
    trial = {r, b};
    if (trial >= {1'b0, d}) div_bit = {1'b1, DEN_W'(trial - {1'b0, d})};
    else                    div_bit = {1'b0, trial[DEN_W-1:0]};
  endfunction

  assign ld_step  = div_bit('0, numerator[NUM_W-1], divisor);
  assign it_step  = div_bit(rem, quo[NUM_W-1], den);
  assign quotient = quo;

  // Load on Start (first bit done immediately), then iterate until the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      den  <= '0;
      quo  <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          rem  <= ld_step[DEN_W-1:0];
          quo  <= {numerator[NUM_W-2:0], ld_step[DEN_W]};
          den  <= divisor;
          cnt  <= CNT_W'(NUM_W - 1);
          busy <= 1'b1;
        end
      end else begin
        rem <= it_step[DEN_W-1:0];
        quo <= {quo[NUM_W-2:0], it_step[DEN_W]};
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/step_clock_gen.sv
// Tempo-driven step clock: converts BPM into a per-step period with an
// iterative divider and emits a Step pulse train with a wrapping step index.
module step_clock_gen
  import step_seq_pkg::*;
#(
  parameter int CLK_HZ         = step_seq_pkg::CLK_HZ,
  parameter int STEPS_PER_BEAT = step_seq_pkg::STEPS_PER_BEAT,
  parameter int NUM_STEPS      = step_seq_pkg::NUM_STEPS,
  parameter int PULSE_W        = step_seq_pkg::PULSE_W,
  parameter int BPM_MIN        = step_seq_pkg::BPM_MIN,
  parameter int BPM_MAX        = step_seq_pkg::BPM_MAX
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Play,
  input  logic [7:0]                   BPM,
  output logic                         Step,
  output logic [$clog2(NUM_STEPS)-1:0] StepIndex,
  output logic                         LoopWrap,
  output logic                         Running,
  output logic                         PeriodValid
);

  localparam int IDX_W = $clog2(NUM_STEPS);
  // Computed in 64 bits: CLK_HZ*60 overflows 32-bit int at realistic clocks.
  localparam logic [63:0]         NUM_64  = 64'(CLK_HZ) * 64'd60 / 64'(STEPS_PER_BEAT);
  localparam logic [PERIOD_W-1:0] DIV_NUM = NUM_64[PERIOD_W-1:0];

  // Tempo tracking
  logic [7:0]          bpm_eff;
  logic [7:0]          bpm_lat;
  logic                started;      // low only on the first cycle out of reset
  logic                pending;      // a tempo change arrived while the divider was busy
  logic                tempo_change;
  logic                div_start;
  logic [7:0]          div_den;
  logic                div_busy;
  logic                div_done;
  logic [PERIOD_W-1:0] div_q;
  logic [PERIOD_W-1:0] next_period;

  // Step sequencing
  step_state_e         state;
  logic [PERIOD_W-1:0] tick_cnt;
  logic [PERIOD_W-1:0] tick_nxt;
  logic [PERIOD_W-1:0] active_period;
  logic [IDX_W-1:0]    idx_nxt;
  logic                boundary;
  logic                enter_run;

  assign bpm_eff      = clamp_bpm(BPM, BPM_MIN, BPM_MAX);
  assign tempo_change = !started || (bpm_eff != bpm_lat);
  // A change seen this cycle goes straight in; otherwise replay the latched value.
  assign div_start    = !div_busy && (tempo_change || pending);
  assign div_den      = tempo_change ? bpm_eff : bpm_lat;

  step_period_div #(
    .NUM_W (PERIOD_W),
    .DEN_W (8)
  ) u_div (
    .clk       (Clock),
    .rst       (Reset),
    .start     (div_start),
    .numerator (DIV_NUM),
    .divisor   (div_den),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q)
  );

  // Latch tempo changes, queue a re-divide while busy, capture finished periods.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      started     <= 1'b0;
      bpm_lat     <= '0;
      pending     <= 1'b0;
      PeriodValid <= 1'b0;
      next_period <= '0;
    end else begin
      started <= 1'b1;
      if (tempo_change) bpm_lat <= bpm_eff;
      if (div_start)         pending <= 1'b0;
      else if (tempo_change) pending <= 1'b1;
      if (div_done) begin
        PeriodValid <= 1'b1;
        next_period <= div_q;
      end
    end
  end

  assign tick_nxt  = tick_cnt + 1'b1;
  assign idx_nxt   = StepIndex + 1'b1;
  assign boundary  = (tick_cnt == active_period - 1'b1);
  // From IDLE or WAIT, a valid period with Play high starts the pattern.
  assign enter_run = (state != RUN) && Play && PeriodValid;

  // Run/stop FSM with registered Step, StepIndex, LoopWrap and Running.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      active_period <= '0;
      Step          <= 1'b0;
      StepIndex     <= '0;
      LoopWrap      <= 1'b0;
      Running       <= 1'b0;
    end else if (enter_run) begin
      state         <= RUN;
      tick_cnt      <= '0;
      active_period <= next_period;
      Step          <= 1'b1;
      StepIndex     <= '0;
      LoopWrap      <= 1'b0;
      Running       <= 1'b1;
    end else begin
      case (state)
        IDLE: if (Play) state <= WAIT;
        WAIT: if (!Play) state <= IDLE;
        RUN: begin
          if (!Play) begin
            // Stop wins over a coinciding boundary; an in-flight pulse is cut.
            state     <= IDLE;
            tick_cnt  <= '0;
            Step      <= 1'b0;
            StepIndex <= '0;
            LoopWrap  <= 1'b0;
            Running   <= 1'b0;
          end else if (boundary) begin
            // New period takes effect only here, so a step never changes length mid-way.
            tick_cnt      <= '0;
            active_period <= next_period;
            Step          <= 1'b1;
            StepIndex     <= idx_nxt;
            LoopWrap      <= (idx_nxt == '0);
          end else begin
            tick_cnt <= tick_nxt;
            Step     <= (tick_nxt < PERIOD_W'(PULSE_W));
            LoopWrap <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen: timestamp-based tempo/step model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_step_clock_gen;

  localparam int STEP_NUM = 800 * 60 / 4;  // 12000 cycles*bpm per step

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Play  = 1'b0;
  logic [7:0] BPM   = 8'd120;
  logic       Step, LoopWrap, Running, PeriodValid;
  logic [3:0] StepIndex;

  step_clock_gen #(
    .CLK_HZ(800), .STEPS_PER_BEAT(4), .NUM_STEPS(16),
    .PULSE_W(4), .BPM_MIN(40), .BPM_MAX(240)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Play(Play), .BPM(BPM),
    .Step(Step), .StepIndex(StepIndex), .LoopWrap(LoopWrap),
    .Running(Running), .PeriodValid(PeriodValid)
  );

  always #5 Clock = ~Clock;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Divider modelled as a job: result = STEP_NUM/bpm, delivered 32 cycles
  // after the start cycle. Steps modelled by the time of the last rise.
  int mc = 0;
  int m_mode = 0;            // 0 idle, 1 waiting for period, 2 running
  int m_idx = 0, m_rise = 0, m_active = 0, m_next = 0, m_lat = 0;
  int m_job_s = 0, m_job_res = 0, m_eff = 0, m_new_next = 0;
  bit m_wrap = 0, m_pv = 0, m_started = 0, m_pend = 0, m_job = 0;
  bit m_step = 0, m_run = 0, m_ok = 0;
  bit m_chg, m_busy, m_done, m_go, m_new_pv;

  function automatic int clampi(input int b);
    if (b < 40) return 40;
    if (b > 240) return 240;
    return b;
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      m_mode = 0; m_idx = 0; m_wrap = 0; m_pv = 0; m_started = 0;
      m_pend = 0; m_job = 0; m_ok = 1;
    end else begin
      m_eff  = clampi(int'(BPM));
      m_chg  = !m_started || (m_eff != m_lat);
      m_busy = m_job && (mc > m_job_s) && (mc < m_job_s + 32);
      m_done = m_job && (mc == m_job_s + 32);
      m_new_pv = m_pv; m_new_next = m_next;
      if (m_done) begin m_new_pv = 1; m_new_next = m_job_res; end
      m_started = 1;
      if (m_chg) m_lat = m_eff;
      m_go = !m_busy && (m_chg || m_pend);
      if (m_go) begin m_job = 1; m_job_s = mc; m_job_res = STEP_NUM / m_lat; m_pend = 0; end
      else if (m_chg) m_pend = 1;
      if (m_mode != 2 && Play && m_pv) begin
        m_mode = 2; m_rise = mc + 1; m_idx = 0; m_wrap = 0; m_active = m_next;
      end else if (m_mode == 0) begin
        if (Play) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!Play) m_mode = 0;
      end else if (!Play) begin
        m_mode = 0; m_idx = 0; m_wrap = 0;
      end else if (mc == m_rise + m_active - 1) begin
        m_rise = mc + 1; m_idx = (m_idx + 1) % 16; m_wrap = (m_idx == 0); m_active = m_next;
      end else begin
        m_wrap = 0;
      end
      m_pv = m_new_pv; m_next = m_new_next;
    end
    m_run  = (m_mode == 2);
    m_step = m_run && ((mc + 1 - m_rise) < 4);
    mc++;
  end

  // Every-cycle comparison against the model.
  always @(negedge Clock) begin
    if (m_ok) begin
      n_assert++;
      if (Step !== m_step || StepIndex !== 4'(m_idx) || LoopWrap !== m_wrap ||
          Running !== m_run || PeriodValid !== m_pv) begin
        n_fail++;
        $display("FAIL model t=%0t: Step/Idx/Wrap/Run/PV got %b/%0d/%b/%b/%b expected %b/%0d/%b/%b/%b",
                 $time, Step, StepIndex, LoopWrap, Running, PeriodValid,
                 m_step, m_idx, m_wrap, m_run, m_pv);
      end
    end
  end

  // ---------------- step monitor ----------------
  int ncyc = 0;
  int rise_q[$], ridx_q[$], rwrap_q[$], width_q[$];
  int wrap_cnt = 0, hi_len = 0;
  logic prev_step = 1'b0;

  always @(negedge Clock) begin
    ncyc++;
    if (Step === 1'b1 && prev_step !== 1'b1) begin
      rise_q.push_back(ncyc);
      ridx_q.push_back(int'(StepIndex));
      rwrap_q.push_back(int'(LoopWrap));
    end
    if (LoopWrap === 1'b1) wrap_cnt++;
    if (Step === 1'b1) hi_len++;
    else begin
      if (hi_len > 0) width_q.push_back(hi_len);
      hi_len = 0;
    end
    prev_step = Step;
  end

  task automatic clear_mon();
    rise_q.delete(); ridx_q.delete(); rwrap_q.delete(); width_q.delete();
    wrap_cnt = 0;
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic wait_pv(output int k);
    k = 0;
    while (PeriodValid !== 1'b1 && k < 100) begin tick(); k++; end
  endtask

  task automatic wait_rise(output int k);
    k = 0;
    while (rise_q.size() == 0 && k < 300) begin tick(); k++; end
  endtask

  // ---------------- directed scenarios ----------------
  int k;
  int bpm_tab[3] = '{10, 255, 0};
  int per_tab[3] = '{300, 50, 300};

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset_step", int'(Step), 0);
    check("reset_running", int'(Running), 0);
    check("reset_pv", int'(PeriodValid), 0);
    Reset = 1'b0;
    wait_pv(k);
    check("pv_latency", k, 33);

    // First step and steady 120 BPM stream
    clear_mon();
    Play = 1'b1;
    tick();
    check("first_step", int'(Step), 1);
    check("first_idx", int'(StepIndex), 0);
    check("first_running", int'(Running), 1);
    repeat (1650) tick();
    check("period_120_a", q_at(rise_q, 1) - q_at(rise_q, 0), 100);
    check("period_120_b", q_at(rise_q, 5) - q_at(rise_q, 4), 100);
    check("width_0", q_at(width_q, 0), 4);
    check("width_7", q_at(width_q, 7), 4);
    check("idx_3", q_at(ridx_q, 3), 3);
    check("idx_15", q_at(ridx_q, 15), 15);
    check("idx_16", q_at(ridx_q, 16), 0);
    check("no_wrap_first", q_at(rwrap_q, 0), 0);
    check("wrap_at_17th", q_at(rwrap_q, 16), 1);
    check("wrap_span", q_at(rise_q, 16) - q_at(rise_q, 0), 1600);
    check("wrap_count", wrap_cnt, 1);

    // Tempo change mid-step: current step keeps 100, then 50
    clear_mon();
    wait_rise(k);
    check("t3_rise_seen", int'(rise_q.size() > 0), 1);
    repeat (20) tick();
    BPM = 8'd240;
    repeat (260) tick();
    check("t3_old_period", q_at(rise_q, 1) - q_at(rise_q, 0), 100);
    check("t3_new_period_a", q_at(rise_q, 2) - q_at(rise_q, 1), 50);
    check("t3_new_period_b", q_at(rise_q, 3) - q_at(rise_q, 2), 50);

    // Clamping
    for (int i = 0; i < 3; i++) begin
      Play = 1'b0;
      BPM = 8'(bpm_tab[i]);
      repeat (40) tick();
      clear_mon();
      Play = 1'b1;
      repeat (2 * per_tab[i] + 20) tick();
      check($sformatf("clamp_bpm%0d_a", bpm_tab[i]), q_at(rise_q, 1) - q_at(rise_q, 0), per_tab[i]);
      check($sformatf("clamp_bpm%0d_b", bpm_tab[i]), q_at(rise_q, 2) - q_at(rise_q, 1), per_tab[i]);
    end

    // Stop during a pulse
    Play = 1'b0;
    BPM = 8'd120;
    repeat (40) tick();
    Play = 1'b1;
    tick();
    check("t5_rise", int'(Step), 1);
    tick();
    Play = 1'b0;
    tick();
    check("t5_step_cut", int'(Step), 0);
    check("t5_idx", int'(StepIndex), 0);
    check("t5_running", int'(Running), 0);

    // Stop on a boundary cycle
    Play = 1'b1;
    tick();
    repeat (99) tick();
    check("t5b_running", int'(Running), 1);
    Play = 1'b0;
    clear_mon();
    repeat (10) tick();
    check("t5b_no_rise", rise_q.size(), 0);
    check("t5b_stopped", int'(Running), 0);

    // Reset mid-run with Play held high
    Play = 1'b1;
    repeat (102) tick();
    check("t6_pre_step", int'(Step), 1);
    Reset = 1'b1;
    tick();
    check("t6_step", int'(Step), 0);
    check("t6_idx", int'(StepIndex), 0);
    check("t6_running", int'(Running), 0);
    check("t6_pv", int'(PeriodValid), 0);
    check("t6_wrap", int'(LoopWrap), 0);
    tick();
    Reset = 1'b0;
    wait_pv(k);
    check("t6_pv_latency", k, 33);
    tick();
    check("t6_resume_step", int'(Step), 1);
    check("t6_resume_idx", int'(StepIndex), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
